uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo_if.sv | 9 +
 rtl/uart_tx_fifo.sv | 147 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - byte handshake between a producer and the UART transmit FIFO
interface uart_tx_fifo_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding an 8N1 UART transmitter
module uart_tx_fifo #(
  parameter int DELAY_FRAMES = 234,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  uart_tx_fifo_if.slave                 tx_if,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DELAY_FRAMES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DELAY_FRAMES - 1);
  localparam logic [AW:0]   DEPTH_L = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
  logic          push, pop, cnt_last, fifo_nonempty;

  assign tx_if.tx_ready = (count_q != DEPTH_L);
  assign push           = tx_if.tx_valid && tx_if.tx_ready;
  assign cnt_last       = (cnt_q == CNT_MAX);
  assign fifo_nonempty  = (count_q != '0);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Popping loads the head straight into the shift register and starts the start bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (fifo_nonempty) begin
          pop     = 1'b1;
          shreg_d = mem_q[rd_ptr_q];
          tx_d    = 1'b0;
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_last) begin
          tx_d    = shreg_q[0];
          cnt_d   = '0;
          idx_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            idx_d   = idx_q + 1'b1;
            tx_d    = shreg_q[1];
            shreg_d = {1'b0, shreg_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (fifo_nonempty) begin
            pop     = 1'b1;
            shreg_d = mem_q[rd_ptr_q];
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // Storage is not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_if.tx_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shreg_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shreg_q  <= shreg_d;
      tx_q     <= tx_d;
    end
  end

  assign uart_tx    = tx_q;
  assign busy       = (state_q != IDLE);
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo with a line-level receiver model
module tb_uart_tx_fifo;
  localparam int DA = 234;
  localparam int DB = 2;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo_if if_a ();
  uart_tx_fifo_if if_b ();

  logic       tx_a, busy_a, tx_b, busy_b;
  logic [2:0] cnt_a, cnt_b;

  uart_tx_fifo #(.DELAY_FRAMES(DA), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .tx_if(if_a),
    .uart_tx(tx_a), .busy(busy_a), .fifo_count(cnt_a)
  );

  uart_tx_fifo #(.DELAY_FRAMES(DB), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .tx_if(if_b),
    .uart_tx(tx_b), .busy(busy_b), .fifo_count(cnt_b)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] rx_a[$];
  logic [7:0] rx_b[$];
  int         st_a[$];
  int         st_b[$];
  int         ferr_a = 0;
  int         ferr_b = 0;
  int         acc_b  = 0;

  function automatic logic line(input int which);
    return (which == 0) ? tx_a : tx_b;
  endfunction

  // Receiver model: samples once per cycle, demands exact bit windows, records frame starts.
  task automatic mon(input int which, input int d);
    logic [7:0] b;
    logic       l;
    bit         bad;
    bit         abort;
    forever begin
      @(posedge clk); #1;
      if (reset_n === 1'b1 && line(which) === 1'b0) begin
        b = '0; bad = 0; abort = 0;
        if (which == 0) st_a.push_back(cyc); else st_b.push_back(cyc);
        for (int s = 1; s < 10 * d; s++) begin
          @(posedge clk); #1;
          if (reset_n !== 1'b1) begin abort = 1; break; end
          l = line(which);
          if (s < d) begin
            if (l !== 1'b0) bad = 1;
          end else if (s >= 9 * d) begin
            if (l !== 1'b1) bad = 1;
          end else if (s % d == 0) begin
            b[s / d - 1] = l;
          end else if (l !== b[s / d - 1]) begin
            bad = 1;
          end
        end
        if (!abort) begin
          if (which == 0) begin
            rx_a.push_back(b);
            if (bad) ferr_a++;
          end else begin
            rx_b.push_back(b);
            if (bad) ferr_b++;
          end
        end
      end
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge (acc = that edge).
  task automatic push(input int which, input logic [7:0] data, input int budget,
                      output int acc, output bit ok);
    ok = 0; acc = -1;
    for (int w = 0; w < budget; w++) begin
      if (which == 0) begin
        if_a.tx_valid = 1'b1;
        if (if_a.tx_ready) begin if_a.tx_data = data; ok = 1; end
        else if_a.tx_data = 8'($urandom);
      end else begin
        if_b.tx_valid = 1'b1;
        if (if_b.tx_ready) begin if_b.tx_data = data; ok = 1; end
        else if_b.tx_data = 8'($urandom);
      end
      @(negedge clk);
      if (ok) begin
        acc = cyc;
        if (which == 1) acc_b++;
        break;
      end
    end
    if (which == 0) if_a.tx_valid = 1'b0; else if_b.tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int which, input int budget, output bit ok);
    ok = 0;
    for (int w = 0; w < budget; w++) begin
      @(negedge clk);
      if (which == 0 ? (!busy_a && cnt_a == 0) : (!busy_b && cnt_b == 0)) begin
        ok = 1;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    if_a.tx_valid = 1'b0; if_a.tx_data = '0;
    if_b.tx_valid = 1'b0; if_b.tx_data = '0;
    repeat (3) @(negedge clk);
    n_chk++; if (tx_a !== 1'b1) begin n_fail++; $display("FAIL reset_tx_a: got %b want 1", tx_a); end
    n_chk++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy_a: got %b want 0", busy_a); end
    n_chk++; if (cnt_a !== 3'd0) begin n_fail++; $display("FAIL reset_count_a: got %0d want 0", cnt_a); end
    n_chk++; if (if_a.tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_a: got %b want 1", if_a.tx_ready); end
    n_chk++; if (tx_b !== 1'b1) begin n_fail++; $display("FAIL reset_tx_b: got %b want 1", tx_b); end
    n_chk++; if (cnt_b !== 3'd0) begin n_fail++; $display("FAIL reset_count_b: got %0d want 0", cnt_b); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (tx_a !== 1'b1 || busy_a !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle: tx=%b busy=%b want 1/0", tx_a, busy_a);
    end
  endtask

  task automatic test_single();
    int acc, bc;
    bit ok;
    rx_a.delete(); st_a.delete(); ferr_a = 0; bc = 0;
    push(0, 8'h55, 4, acc, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL single_accept: not accepted, want accepted"); end
    for (int i = 0; i < 10 * DA + 60; i++) begin
      @(negedge clk);
      if (busy_a) bc++;
    end
    n_chk++; if (bc != 10 * DA) begin n_fail++; $display("FAIL single_busy_cycles: got %0d want %0d", bc, 10 * DA); end
    n_chk++; if (st_a.size() != 1 || st_a[0] != acc + 1) begin
      n_fail++; $display("FAIL single_latency: starts=%0d first=%0d want 1 at %0d", st_a.size(), (st_a.size() > 0) ? st_a[0] : -1, acc + 1);
    end
    n_chk++; if (rx_a.size() != 1 || rx_a[0] !== 8'h55) begin
      n_fail++; $display("FAIL single_byte: n=%0d byte=%h want 1 x 55", rx_a.size(), (rx_a.size() > 0) ? rx_a[0] : 8'hxx);
    end
    n_chk++; if (ferr_a != 0) begin n_fail++; $display("FAIL single_frame_shape: errors=%0d want 0", ferr_a); end
  endtask

  task automatic test_burst_full();
    int acc[6];
    int gap_err;
    bit ok, all_ok;
    logic [7:0] expb;
    rx_a.delete(); st_a.delete(); ferr_a = 0; all_ok = 1;
    for (int i = 0; i < 5; i++) begin
      push(0, 8'(8'h41 + i), 10, acc[i], ok);
      if (!ok) all_ok = 0;
    end
    n_chk++; if (!all_ok || acc[4] - acc[0] != 4) begin
      n_fail++; $display("FAIL burst_accept: ok=%b span=%0d want 1/4", all_ok, acc[4] - acc[0]);
    end
    n_chk++; if (cnt_a !== 3'd4 || if_a.tx_ready !== 1'b0) begin
      n_fail++; $display("FAIL burst_full: count=%0d ready=%b want 4/0", cnt_a, if_a.tx_ready);
    end
    // Valid is held with scrambled data across the whole stall and the pop edge.
    push(0, 8'h46, 3 * 10 * DA, acc[5], ok);
    n_chk++; if (!ok || acc[5] != acc[0] + 1 + 10 * DA + 1) begin
      n_fail++; $display("FAIL stall_accept_edge: got %0d want %0d", acc[5], acc[0] + 2 + 10 * DA);
    end
    n_chk++; if (cnt_a !== 3'd4) begin n_fail++; $display("FAIL stall_count_refill: got %0d want 4", cnt_a); end
    wait_idle(0, 7 * 10 * DA, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL burst_drain_timeout: still busy, want idle"); end
    n_chk++; if (rx_a.size() != 6) begin n_fail++; $display("FAIL burst_count_rx: got %0d want 6", rx_a.size()); end
    for (int i = 0; i < 6 && i < rx_a.size(); i++) begin
      expb = 8'(8'h41 + i);
      n_chk++; if (rx_a[i] !== expb) begin n_fail++; $display("FAIL burst_byte%0d: got %h want %h", i, rx_a[i], expb); end
    end
    gap_err = 0;
    if (st_a.size() < 6) gap_err = 99;
    else for (int i = 1; i < 6; i++) if (st_a[i] - st_a[i - 1] != 10 * DA) gap_err++;
    n_chk++; if (gap_err != 0) begin n_fail++; $display("FAIL burst_back_to_back: gaps=%0d want 0", gap_err); end
    n_chk++; if (st_a.size() < 5 || st_a[4] + 10 * DA - st_a[0] != 11700) begin
      n_fail++; $display("FAIL burst_total_cycles: got %0d want 11700", (st_a.size() < 5) ? -1 : st_a[4] + 10 * DA - st_a[0]);
    end
    n_chk++; if (ferr_a != 0) begin n_fail++; $display("FAIL burst_frame_shape: errors=%0d want 0", ferr_a); end
  endtask

  task automatic test_reset_mid();
    int acc0, acc1, target, guard;
    bit ok;
    rx_a.delete(); st_a.delete(); ferr_a = 0;
    push(0, 8'hA5, 4, acc0, ok);
    push(0, 8'h11, 4, acc1, ok);
    push(0, 8'h22, 4, acc1, ok);
    target = acc0 + 1 + 4 * DA + DA / 2;
    guard = 0;
    while (cyc < target && guard < 5000) begin @(negedge clk); guard++; end
    n_chk++; if (tx_a !== 1'b0 || cnt_a !== 3'd2) begin
      n_fail++; $display("FAIL mid_bit3_state: tx=%b count=%0d want 0/2", tx_a, cnt_a);
    end
    #2 reset_n = 1'b0;
    #1;
    n_chk++; if (tx_a !== 1'b1) begin n_fail++; $display("FAIL async_reset_tx: got %b want 1", tx_a); end
    n_chk++; if (cnt_a !== 3'd0 || if_a.tx_ready !== 1'b1) begin
      n_fail++; $display("FAIL async_reset_fifo: count=%0d ready=%b want 0/1", cnt_a, if_a.tx_ready);
    end
    n_chk++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy: got %b want 0", busy_a); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3 * 10 * DA) @(negedge clk);
    n_chk++; if (st_a.size() != 1 || rx_a.size() != 0) begin
      n_fail++; $display("FAIL reset_discard: starts=%0d bytes=%0d want 1/0", st_a.size(), rx_a.size());
    end
    push(0, 8'h3C, 1, acc0, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL first_push_after_reset: not accepted, want accepted"); end
    wait_idle(0, 2 * 10 * DA, ok);
    n_chk++; if (!ok || rx_a.size() != 1 || rx_a[0] !== 8'h3C) begin
      n_fail++; $display("FAIL after_reset_byte: n=%0d byte=%h want 1 x 3c", rx_a.size(), (rx_a.size() > 0) ? rx_a[0] : 8'hxx);
    end
  endtask

  task automatic test_min_timing();
    int acc0, acc1;
    bit ok;
    rx_b.delete(); st_b.delete(); ferr_b = 0; acc_b = 0;
    push(1, 8'h00, 4, acc0, ok);
    push(1, 8'hFF, 4, acc1, ok);
    wait_idle(1, 200, ok);
    n_chk++; if (!ok || rx_b.size() != 2 || rx_b[0] !== 8'h00 || rx_b[1] !== 8'hFF) begin
      n_fail++; $display("FAIL min_bytes: n=%0d got %h %h want 00 ff", rx_b.size(),
                         (rx_b.size() > 0) ? rx_b[0] : 8'hxx, (rx_b.size() > 1) ? rx_b[1] : 8'hxx);
    end
    n_chk++; if (st_b.size() != 2 || st_b[0] != acc0 + 1 || st_b[1] - st_b[0] != 20) begin
      n_fail++; $display("FAIL min_frame_timing: starts=%0d first=%0d want %0d spacing 20", st_b.size(),
                         (st_b.size() > 0) ? st_b[0] : -1, acc0 + 1);
    end
    n_chk++; if (ferr_b != 0) begin n_fail++; $display("FAIL min_frame_shape: errors=%0d want 0", ferr_b); end
  endtask

  task automatic test_loopback();
    int acc;
    bit ok;
    rx_b.delete(); st_b.delete(); ferr_b = 0; acc_b = 0;
    for (int i = 0; i < 10; i++) push(1, 8'(i), 200, acc, ok);
    wait_idle(1, 400, ok);
    n_chk++; if (!ok || rx_b.size() != 10) begin n_fail++; $display("FAIL loopback_count: got %0d want 10", rx_b.size()); end
    for (int i = 0; i < 10 && i < rx_b.size(); i++) begin
      n_chk++; if (rx_b[i] !== 8'(i)) begin n_fail++; $display("FAIL loopback_byte%0d: got %h want %h", i, rx_b[i], 8'(i)); end
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] d;
    int  model_cnt;
    bit  v, ok;
    rx_b.delete(); st_b.delete(); ferr_b = 0; acc_b = 0;
    for (int i = 0; i < 400; i++) begin
      model_cnt = acc_b - st_b.size();
      n_chk++; if (int'(cnt_b) != model_cnt) begin
        n_fail++; $display("FAIL rand_count@%0d: got %0d want %0d", cyc, cnt_b, model_cnt);
      end
      n_chk++; if (if_b.tx_ready !== (model_cnt != 4)) begin
        n_fail++; $display("FAIL rand_ready@%0d: got %b want %b", cyc, if_b.tx_ready, model_cnt != 4);
      end
      v = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      if_b.tx_valid = v;
      if_b.tx_data  = d;
      if (v && model_cnt != 4) begin exp_q.push_back(d); acc_b++; end
      @(negedge clk);
    end
    if_b.tx_valid = 1'b0;
    wait_idle(1, 300, ok);
    n_chk++; if (!ok || rx_b.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rand_rx_count: got %0d want %0d", rx_b.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_b.size(); i++) begin
      n_chk++; if (rx_b[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_byte%0d: got %h want %h", i, rx_b[i], exp_q[i]); end
    end
    n_chk++; if (ferr_b != 0) begin n_fail++; $display("FAIL rand_frame_shape: errors=%0d want 0", ferr_b); end
  endtask

  initial begin
    fork
      mon(0, DA);
      mon(1, DB);
    join_none
    test_reset();
    test_single();
    test_burst_full();
    test_reset_mid();
    test_min_timing();
    test_loopback();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
